flipflop_in_arbiter: RTL and testbench
======================================

// Module: flipflop_in_arbiter
// PURPOSE
//  Shares one flipflop_in instance (set/reset pulse inputs, latched bit output) between NREQ requesters.
//  Round-robin arbitration, one pulse per operation, read-back confirm of ff_bit, minimum hold between changes.
//  Sits between plugin/interface logic and the flipflop_in instance; ff_set/ff_reset are its only drivers.
// PARAMETERS
//  NREQ       4   number of requesters, 2..8
//  MIN_HOLD   4   cycles ff_bit is held stable after confirm before the next grant, >=1
//  CONFIRM_TO 8   cycles allowed for ff_bit to reach target after the pulse, >=2
//  DEFAULT    0   reset value of shadow target; equals flipflop_in DEFAULT
// PORTS
//  clk        in   1        single system clock
//  rst_n      in   1        synchronous reset, active-low
//  req_set    in   NREQ     level request per requester: drive bit to 1
//  req_reset  in   NREQ     level request per requester: drive bit to 0
//  ack        out  NREQ     one-cycle done pulse to the granted requester
//  grant_id   out  clog2(NREQ)  index of current/last grantee
//  busy       out  1        high in any state except IDLE
//  error      out  1        sticky: confirm timeout seen
//  ff_set     out  1        one-cycle set pulse to flipflop_in
//  ff_reset   out  1        one-cycle reset pulse to flipflop_in
//  ff_bit     in   1        read-back of flipflop_in bit
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, ack=0, ff_set=0, ff_reset=0, busy=0, error=0, grant_id=0,
//   rr pointer=0, target=DEFAULT. Reset mid-operation abandons it; no ack, no pulse in the following cycle.
//  Requests are levels; requester holds until its ack, must drop in the cycle after ack.
//  Per requester: req_set&req_reset both high -> treated as reset (reset wins).
//  FSM: IDLE -> ISSUE -> CONFIRM -> HOLD -> DONE -> IDLE; plus IDLE -> DONE (no-op path).
//   IDLE: pending = req_set|req_reset. If any: grant first pending at or after rr pointer (wrap NREQ-1 -> 0),
//    latch grant_id and target. If target == ff_bit -> DONE (no pulse). Else -> ISSUE.
//   ISSUE: exactly one cycle; ff_set=target, ff_reset=~target. -> CONFIRM, timer cleared.
//   CONFIRM: ff_bit==target -> HOLD, counter cleared. Timer reaches CONFIRM_TO -> error<=1, -> HOLD anyway.
//   HOLD: count MIN_HOLD cycles, -> DONE. ff_set/ff_reset low throughout.
//   DONE: ack[grant_id]=1 for one cycle; rr pointer <= grant_id+1 (wrap). -> IDLE.
//  Latency (pulsed path, flipflop_in 1-cycle register): req seen in IDLE cycle 0, pulse cycle 1,
//   confirm cycle 3, ack cycle 4+MIN_HOLD. No-op path: ack cycle 1.
//  Requests dropped before grant: ignored. Dropped after grant: operation completes, ack still pulsed.
//  New requests during busy are only sampled in IDLE; requests are not queued beyond their level.
//  ff_set and ff_reset are never high together; at most one pulse per grant.
//  error clears only on reset. grant_id holds last grantee while IDLE.
// STRUCTURE
//  flipflop_in_arbiter_defs.vh: state encodings (IDLE, ISSUE, CONFIRM, HOLD, DONE), 3-bit state width.
//  Sub-module rr_arbiter #(N): pending vector + pointer -> grant index and valid; combinational, reusable.
//  Top holds FSM, shared timer (width clog2(max(MIN_HOLD,CONFIRM_TO))+1), target/grant registers.
// TESTING (bench instantiates flipflop_in DEFAULT=0 wired to ff_set/ff_reset/ff_bit)
//  1 req_set[0]=1 from cycle 0 -> ff_set pulse at cycle 1, ff_bit=1 at 2, ack[0] at 4+MIN_HOLD=8; busy 1..8.
//  2 req_set[1],req_reset[2],req_set[3] high together, ptr=0 -> grant order 1,2,3; ff_bit 1,0,1; acks 1,2,3.
//  3 ff_bit already 1, req_set[2]=1 -> no ff_set pulse, ack[2] at cycle 1, busy 1 cycle only.
//  4 req_set[0]&req_reset[0] with ff_bit=1 -> ff_reset pulse only, ff_bit=0, ack[0].
//  5 bench forces ff_bit stuck at 0, req_set[0] -> error=1 after CONFIRM_TO=8 cycles, ack[0] still issued, error sticky.
//  6 rst_n=0 during HOLD -> next cycle state IDLE, busy=0, no ack, error=0, grant_id=0.

Source files
------------

// File: rtl/flipflop_in_arbiter_pkg.sv
// Shared types for the flipflop_in arbiter: FSM state encoding and a small sizing helper.
package flipflop_in_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flipflop_in_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first pending index at or after the pointer, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] pending_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] grant_o,
  output logic         valid_o
);

  logic [W-1:0] idx;

  // NOTE: every variable written in an always_comb gets a value before any branch, so no latch is inferred.
  always_comb begin
    grant_o = '0;
    idx     = '0;
    valid_o = |pending_i;
    // Walk offsets from far to near so the closest pending index is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr_i) + k) % N);
      if (pending_i[idx]) grant_o = idx;
    end
  end

endmodule

// File: rtl/flipflop_in_arbiter.sv
// Shares one flipflop_in between NREQ requesters: round-robin grant, single pulse, read-back confirm, hold.
module flipflop_in_arbiter
  import flipflop_in_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int MIN_HOLD   = 4,
  parameter int CONFIRM_TO = 8,
  parameter bit DEFAULT    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_set,
  input  logic [NREQ-1:0]         req_reset,
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    error,
  output logic                    ff_set,
  output logic                    ff_reset,
  input  logic                    ff_bit
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(max_int(MIN_HOLD, CONFIRM_TO)) + 1;

  state_e          state_q, state_d;
  logic [GW-1:0]   gid_q, gid_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic            target_q, target_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            error_q, error_d;

  logic [NREQ-1:0] pending;
  logic [GW-1:0]   rr_grant;
  logic            rr_valid;
  logic            req_target;

  assign pending    = req_set | req_reset;
  // A requester asserting both levels asks for 0.
  assign req_target = req_set[rr_grant] & ~req_reset[rr_grant];

  rr_arbiter #(.N(NREQ), .W(GW)) u_rr (
    .pending_i (pending),
    .ptr_i     (ptr_q),
    .grant_o   (rr_grant),
    .valid_o   (rr_valid)
  );

  // NOTE: state registers use non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gid_q    <= '0;
      ptr_q    <= '0;
      target_q <= DEFAULT;
      timer_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    target_d = target_q;
    timer_d  = timer_q;
    error_d  = error_q;
    ack      = '0;
    ff_set   = 1'b0;
    ff_reset = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          gid_d    = rr_grant;
          target_d = req_target;
          state_d  = (req_target == ff_bit) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ff_set   = target_q;
        ff_reset = ~target_q;
        timer_d  = '0;
        state_d  = ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (ff_bit == target_q) begin
          timer_d = '0;
          state_d = ST_HOLD;
        end else if (timer_q == TW'(CONFIRM_TO - 1)) begin
          // Give up on the read-back but still finish the handshake so the requester is not stranded.
          error_d = 1'b1;
          timer_d = '0;
          state_d = ST_HOLD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (timer_q == TW'(MIN_HOLD)) state_d = ST_DONE;
        else                          timer_d = timer_q + 1'b1;
      end
      ST_DONE: begin
        ack[gid_q] = 1'b1;
        ptr_d      = (gid_q == GW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign grant_id = gid_q;
  assign error    = error_q;

endmodule

// File: tb/tb_flipflop_in_arbiter.sv
// Bench for flipflop_in_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level schedule model.
module tb_flipflop_in_arbiter;

  localparam int NREQ       = 4;
  localparam int MIN_HOLD   = 4;
  localparam int CONFIRM_TO = 8;
  localparam int GW         = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_set = '0;
  logic [NREQ-1:0] req_reset = '0;
  logic [NREQ-1:0] ack;
  logic [GW-1:0]   grant_id;
  logic            busy, error, ff_set, ff_reset, ff_bit;

  // Stand-in for flipflop_in (DEFAULT=0): one-cycle register, optionally masked to stuck-at-0.
  logic ff_q  = 1'b0;
  logic stuck = 1'b0;
  assign ff_bit = stuck ? 1'b0 : ff_q;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_set    = 0;
  int n_rst    = 0;

  flipflop_in_arbiter #(
    .NREQ(NREQ), .MIN_HOLD(MIN_HOLD), .CONFIRM_TO(CONFIRM_TO), .DEFAULT(1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_set   (req_set),
    .req_reset (req_reset),
    .ack       (ack),
    .grant_id  (grant_id),
    .busy      (busy),
    .error     (error),
    .ff_set    (ff_set),
    .ff_reset  (ff_reset),
    .ff_bit    (ff_bit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ff_set === 1'b1)        ff_q <= 1'b1;
    else if (ff_reset === 1'b1) ff_q <= 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp_v);
    end
  endtask

  // ---------------- reference model: per-grant output schedule ----------------
  typedef struct packed {
    logic            busy;
    logic            fs;
    logic            fr;
    logic [NREQ-1:0] ack;
    logic [GW-1:0]   gid;
    logic            err_now;
  } exp_t;

  exp_t          sched[$];
  int            m_ptr   = 0;
  logic [GW-1:0] m_gid   = '0;
  logic          m_err   = 1'b0;
  bit            m_valid = 1'b0;

  function automatic exp_t mk(input logic b, input logic fs, input logic fr,
                              input logic [NREQ-1:0] a, input logic [GW-1:0] gid, input logic en);
    exp_t e;
    e.busy = b; e.fs = fs; e.fr = fr; e.ack = a; e.gid = gid; e.err_now = en;
    return e;
  endfunction

  // Called in an idle cycle: decide the grant from the current levels and queue every later cycle's outputs.
  task automatic model_grant();
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] onehot;
    int   g;
    logic tgt, seen;
    pend = req_set | req_reset;
    g = -1;
    for (int off = 0; off < NREQ; off++)
      if (g < 0 && pend[(m_ptr + off) % NREQ]) g = (m_ptr + off) % NREQ;
    if (g < 0) return;
    tgt    = req_set[g] & ~req_reset[g];
    seen   = stuck ? 1'b0 : ff_q;
    m_gid  = GW'(g);
    m_ptr  = (g + 1) % NREQ;
    onehot = '0;
    onehot[g] = 1'b1;
    if (tgt != seen) begin
      sched.push_back(mk(1'b1, tgt, ~tgt, '0, m_gid, 1'b0));
      for (int k = 0; k < (stuck ? CONFIRM_TO : 1); k++)
        sched.push_back(mk(1'b1, 1'b0, 1'b0, '0, m_gid, 1'b0));
      for (int k = 0; k <= MIN_HOLD; k++)
        sched.push_back(mk(1'b1, 1'b0, 1'b0, '0, m_gid, stuck && k == 0));
    end
    sched.push_back(mk(1'b1, 1'b0, 1'b0, onehot, m_gid, 1'b0));
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    bit   idle_cyc;
    idle_cyc = 1'b0;
    if (m_valid) begin
      if (sched.size() > 0) begin
        e = sched.pop_front();
      end else begin
        e = mk(1'b0, 1'b0, 1'b0, '0, m_gid, 1'b0);
        idle_cyc = 1'b1;
      end
      if (e.err_now) m_err = 1'b1;
      check("cycle {busy,set,rst,ack,gid,err}",
            32'({busy, ff_set, ff_reset, ack, grant_id, error}),
            32'({e.busy, e.fs, e.fr, e.ack, e.gid, m_err}));
    end
    if (ff_set === 1'b1) n_set++;
    if (ff_reset === 1'b1) n_rst++;
    if (!rst_n) begin
      sched.delete();
      m_ptr   = 0;
      m_gid   = '0;
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid && idle_cyc) begin
      model_grant();
    end
  end

  // ---------------- directed helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int idx, input int t0, input int budget, output int lat);
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (ack[idx] === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) check("ack wait expired", 32'(0), 32'(1));
  endtask

  task automatic wait_any(input int budget, output int idx);
    idx = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) idx = i;
      if (idx >= 0) break;
    end
    if (idx < 0) check("any-ack wait expired", 32'(0), 32'(1));
  endtask

  task automatic random_run(input int cycles);
    logic [NREQ-1:0] a;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      a = ack;
      next_cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (a[i]) begin
          req_set[i] = 1'b0;
          req_reset[i] = 1'b0;
        end else if (!(req_set[i] | req_reset[i])) begin
          if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 2))
              0:       req_set[i] = 1'b1;
              1:       req_reset[i] = 1'b1;
              default: begin req_set[i] = 1'b1; req_reset[i] = 1'b1; end
            endcase
          end
        end else if ($urandom_range(0, 99) == 0) begin
          req_set[i] = 1'b0;
          req_reset[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat, idx, s0, r0;
    int order[3];
    logic ffv[3];

    // Reset state
    rst_n = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset busy", 32'(busy), 32'(0));
    check("reset error", 32'(error), 32'(0));
    check("reset grant_id", 32'(grant_id), 32'(0));
    check("reset ack", 32'(ack), 32'(0));
    check("reset pulses", 32'({ff_set, ff_reset}), 32'(0));
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // 1: set from requester 0, pulsed path
    s0 = n_set;
    req_set[0] = 1'b1;
    t0 = cyc;
    wait_ack(0, t0, 40, lat);
    check("t1 ack latency", 32'(lat), 32'(8));
    check("t1 ff_bit", 32'(ff_q), 32'(1));
    check("t1 set pulses", 32'(n_set - s0), 32'(1));

    // 3: bit already 1, no-op path
    next_cycle();
    req_set[0] = 1'b0;
    req_set[2] = 1'b1;
    s0 = n_set; r0 = n_rst;
    t0 = cyc;
    wait_ack(2, t0, 20, lat);
    check("t3 ack latency", 32'(lat), 32'(1));
    check("t3 no pulses", 32'((n_set - s0) + (n_rst - r0)), 32'(0));
    next_cycle();
    req_set[2] = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // 2: three simultaneous requesters, pointer at 0
    req_set[1] = 1'b1;
    req_reset[2] = 1'b1;
    req_set[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_any(60, idx);
      order[k] = idx;
      ffv[k] = ff_q;
      next_cycle();
      if (idx >= 0) begin
        req_set[idx] = 1'b0;
        req_reset[idx] = 1'b0;
      end
    end
    check("t2 order", 32'({order[0][3:0], order[1][3:0], order[2][3:0]}), 32'('h123));
    check("t2 ff_bit seq", 32'({ffv[0], ffv[1], ffv[2]}), 32'('b101));

    // 4: set and reset together from requester 0 with bit at 1
    next_cycle();
    s0 = n_set; r0 = n_rst;
    req_set[0] = 1'b1;
    req_reset[0] = 1'b1;
    t0 = cyc;
    wait_ack(0, t0, 40, lat);
    check("t4 ff_bit", 32'(ff_q), 32'(0));
    check("t4 pulses {set,rst}", 32'({n_set - s0, n_rst - r0}), {32'(0), 32'(1)});
    check("t4 ack latency", 32'(lat), 32'(8));

    // 5: read-back stuck at 0
    next_cycle();
    req_reset[0] = 1'b0;
    req_set[0] = 1'b1;
    stuck = 1'b1;
    s0 = n_set;
    t0 = cyc;
    wait_ack(0, t0, 60, lat);
    check("t5 ack latency", 32'(lat), 32'(4 + CONFIRM_TO + MIN_HOLD - 1));
    check("t5 error", 32'(error), 32'(1));
    check("t5 set pulses", 32'(n_set - s0), 32'(1));
    next_cycle();
    stuck = 1'b0;
    req_set[0] = 1'b0;

    // 6: reset during HOLD
    next_cycle();
    req_reset[1] = 1'b1;
    t0 = cyc;
    repeat (4) next_cycle();
    @(negedge clk);
    check("t6 error sticky", 32'(error), 32'(1));
    check("t6 busy in op", 32'(busy), 32'(1));
    next_cycle();
    rst_n = 1'b0;
    req_reset[1] = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6 after reset {busy,ack,err,gid,set,rst}",
          32'({busy, ack, error, grant_id, ff_set, ff_reset}), 32'(0));

    // Randomized traffic, healthy read-back
    random_run(1500);

    // Randomized traffic, read-back stuck at 0
    next_cycle();
    rst_n = 1'b0;
    stuck = 1'b1;
    req_set = '0;
    req_reset = '0;
    next_cycle();
    rst_n = 1'b1;
    random_run(600);

    next_cycle();
    req_set = '0;
    req_reset = '0;
    repeat (40) next_cycle();
    stuck = 1'b0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
